// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Shift-add multiplier and restoring divider on operand magnitudes, one bit per cycle, sign fix-up on exit.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    // state | meaning
    // IDLE  | waiting for start; operands latched when a request is accepted
    // CALC  | one multiply or divide step per cycle, busy high
    // FIN   | result valid, done pulses for this single cycle
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg    = a_signed & rs1[XLEN-1];
    assign b_neg    = b_signed & rs2[XLEN-1];
    assign mag_a    = a_neg ? -rs1 : rs1;
    assign mag_b    = b_neg ? -rs2 : rs2;
    assign div_zero = op[2] && (rs2 == '0);
    assign div_ovf  = op[2] && !op[0] && (rs1 == INT_MIN) && (rs2 == '1);

    always_comb begin
        if (div_zero) fast_res = op[1] ? rs1 : '1;
        else          fast_res = op[1] ? '0 : INT_MIN;
    end

    // acc holds product:multiplier for multiply and remainder:quotient for divide
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

    always_comb begin
        if (op_q[2]) begin
            if (div_diff[XLEN]) step = {acc_q[2*XLEN-2:0], 1'b0};
            else                step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            if (acc_q[0]) step = {mul_sum, acc_q[XLEN-1:1]};
            else          step = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    assign prod = neg_q ? -step : step;
    assign quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    assign rem  = rem_neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    acc_d     = {{XLEN{1'b0}}, mag_a};
                    opb_d     = mag_b;
                    cnt_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (div_zero || div_ovf) begin
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_FIN;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // flush wins over everything, including a finishing step
        if (flush) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = (start && (state_q == S_IDLE)) || busy_q;

endmodule
